if1_fetch_buffer: RTL
=====================

// Module: if1_fetch_buffer
// PURPOSE
//   Instruction fetch buffer between the IF1 stage and ID. Captures one fetch
//   packet (pc, instruction, fetch exception) per cycle from IF1 and presents
//   packets to decode in program order. Decouples I-cache return timing from
//   decode stalls. Supplies if1_allowin, which feeds the IF0/IF1 stage register.
// PARAMETERS
//   DEPTH   8   entry count; power of two, >= 2
//   PC_W    32  pc width
//   INST_W  32  instruction width
//   ECODE_W 7   fetch exception code width
// PORTS
//   clk            in   1                  clock, rising edge
//   rstn           in   1                  asynchronous active-low reset
//   flush          in   1                  pipeline flush (redirect/exception/ertn)
//   if1_readygo    in   1                  IF1 holds a valid packet this cycle
//   if1_allowin    out  1                  buffer accepts a packet this cycle
//   if1_pc         in   PC_W               packet pc
//   if1_inst       in   INST_W             packet instruction
//   if1_excp       in   1                  packet carries a fetch exception
//   if1_ecode      in   ECODE_W            exception code (valid when if1_excp)
//   id_allowin     in   1                  ID consumes the head packet
//   fb_valid       out  1                  head packet valid
//   fb_pc          out  PC_W               head pc
//   fb_inst        out  INST_W             head instruction
//   fb_excp        out  1                  head exception flag
//   fb_ecode       out  ECODE_W            head exception code
//   fb_count       out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
//   Reset (rstn=0, async, takes effect without a clock edge): rptr=wptr=0,
//     count=0, excp_lock=0. fb_valid=0, fb_* payload=0, fb_count=0.
//     if1_allowin=1 once rstn deasserts. Storage array is not reset.
//   push = if1_readygo & if1_allowin & ~flush. pop = fb_valid & id_allowin & ~flush.
//   if1_allowin = (count != DEPTH) & ~excp_lock. Combinational from registers only.
//     No dependence on id_allowin, so a pop cannot free a slot in the same cycle.
//   Push writes mem[wptr] and advances wptr. Pop advances rptr.
//     Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
//   Latency: a packet pushed at edge N is visible at the head after edge N (1 cycle).
//     There is no empty-bypass path.
//   Head outputs are read combinationally from mem[rptr]:
//     fb_valid = (count != 0). fb_pc/fb_inst/fb_excp/fb_ecode are forced to 0
//     when fb_valid=0.
//   Exception lock: a push with if1_excp=1 sets excp_lock at that edge. While the
//     lock is set, no further pushes occur. Entries already buffered, including the
//     excepting one, still drain to ID. Only flush or reset clears the lock. Rationale:
//     nothing fetched after a faulting packet is architecturally useful.
//   flush (synchronous, highest priority): at the edge, rptr=wptr=0, count=0,
//     excp_lock=0. A push or pop in the same cycle is discarded. fb_valid=0 in the
//     next cycle. if1_allowin=1 in the next cycle.
//   Full (count=DEPTH): if1_allowin=0, and a pop that cycle does not admit a push.
//   Empty: pop is impossible, and id_allowin is ignored.
//   if1_readygo=1 with if1_allowin=0: no state change. IF1 must hold its packet.
// TESTING
//   1. Reset, id_allowin=0, push pc 0x1c000000/04/08 -> fb_count=3,
//      fb_pc=0x1c000000. Then id_allowin=1 -> 3 pops in order, then fb_valid=0.
//   2. Fill 8 entries with id_allowin=0 -> if1_allowin=0 at count 8. Next cycle
//      if1_readygo=1, id_allowin=1 -> push ignored, count=7, if1_allowin=1 after edge.
//   3. Stream 20 packets with push+pop every cycle (pointer wrap) -> order and
//      payload preserved, fb_count held at 1.
//   4. count=5 with flush=1 and a simultaneous push -> next cycle fb_count=0,
//      fb_valid=0, payload=0, pushed packet absent.
//   5. Push if1_excp=1, if1_ecode=0x08 at slot 3 -> if1_allowin=0 from the next
//      cycle. Head drains to the excepting entry (fb_excp=1, fb_ecode=0x08). Lock
//      persists while empty until flush, then if1_allowin=1.
//   6. Drop rstn mid-stream between clock edges -> fb_valid=0 and fb_count=0
//      immediately. Resume after release with correct order.

Source files
------------

// File: rtl/if1_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if1_fetch_buffer
//  Brief    : In-order instruction fetch buffer between IF1 and ID. Captures
//             one fetch packet per cycle, presents the oldest packet to
//             decode, and blocks further fetches after a faulting packet.
//  Revision : 1.0 - initial release
// ============================================================================
module if1_fetch_buffer #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int ECODE_W = 7
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     if1_readygo,
    output logic                     if1_allowin,
    input  logic [PC_W-1:0]          if1_pc,
    input  logic [INST_W-1:0]        if1_inst,
    input  logic                     if1_excp,
    input  logic [ECODE_W-1:0]       if1_ecode,
    input  logic                     id_allowin,
    output logic                     fb_valid,
    output logic [PC_W-1:0]          fb_pc,
    output logic [INST_W-1:0]        fb_inst,
    output logic                     fb_excp,
    output logic [ECODE_W-1:0]       fb_ecode,
    output logic [$clog2(DEPTH):0]   fb_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = PC_W + INST_W + 1 + ECODE_W;

    // Storage is deliberately left unreset; the head is masked while empty.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               excp_lock_q, excp_lock_d;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake qualifiers and next-state computation; flush overrides all.
    always_comb begin
        if1_allowin = (count_q != CNT_W'(DEPTH)) & ~excp_lock_q;
        fb_valid    = (count_q != '0);
        push        = if1_readygo & if1_allowin & ~flush;
        pop         = fb_valid & id_allowin & ~flush;
        wr_entry    = {if1_pc, if1_inst, if1_excp, if1_ecode};

        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        excp_lock_d = excp_lock_q;

        if (flush) begin
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            excp_lock_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
                if (if1_excp) begin
                    excp_lock_d = 1'b1;
                end
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            excp_lock_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            excp_lock_q <= excp_lock_d;
        end
    end

    // Packet storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    // Head packet read, forced to zero while the buffer is empty.
    always_comb begin
        head_entry = mem_q[rptr_q];
        fb_pc      = '0;
        fb_inst    = '0;
        fb_excp    = 1'b0;
        fb_ecode   = '0;
        if (fb_valid) begin
            {fb_pc, fb_inst, fb_excp, fb_ecode} = head_entry;
        end
        fb_count = count_q;
    end

endmodule
`default_nettype wire
